// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Parametrised universal shift register with an auto-serialise burst.
//
// In IDLE the register follows a direct mode control:
//   00 hold, 01 shift right, 10 shift left, 11 parallel load.
// A start pulse in IDLE launches a burst. The burst loads pin, then shifts it
// out over WIDTH cycles in the direction sampled with start. It captures sin
// on each shift, which gives a full-duplex serial exchange.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode[1:0]  manual operation, applied in IDLE when start is low
//   sin        serial data in, used by every shift
//   pin        parallel load data
//   start      launches a burst (single-cycle pulse expected)
//   dir        burst direction sampled with start: 0 right/LSB first, 1 left/MSB first
//   q          register contents
//   sout       serial out: q[0] (dir_r=0) or q[WIDTH-1] (dir_r=1)
//   sout_valid high while a burst bit is presented on sout
//   busy       high while a burst is running
//   done       one-cycle pulse after the final burst shift
module univ_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              dir_reg, dir_next;
  logic              done_reg, done_next;

  logic [WIDTH-1:0]  shr;
  logic [WIDTH-1:0]  shl;

  // Shifted versions of q. sin always enters at the end opposite the exit bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_r_top
        assign shr[gi] = sin;
      end else begin : g_r_mid
        assign shr[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_l_bot
        assign shl[gi] = sin;
      end else begin : g_l_mid
        assign shl[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= RESET_VAL;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // start takes priority over mode and begins a burst of WIDTH shifts.
          q_next     = pin;
          dir_next   = dir;
          cnt_next   = CNT_LAST;
          state_next = RUN;
        end else begin
          case (mode)
            2'b01:   q_next = shr;
            2'b10:   q_next = shl;
            2'b11:   q_next = pin;
            default: q_next = q_reg;
          endcase
        end
      end
      RUN: begin
        q_next = dir_reg ? shl : shr;
        if (cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign q          = q_reg;
  assign sout       = dir_reg ? q_reg[WIDTH-1] : q_reg[0];
  assign busy       = (state_reg == RUN);
  assign sout_valid = (state_reg == RUN);
  assign done       = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg. It runs three instances on shared stimulus:
// WIDTH=4 with reset value 0, WIDTH=4 with reset value 1010, and WIDTH=2 with
// reset value 01. A behavioural model tracks each instance as a word and a
// count of shifts still to do. Directed scenarios come first, then random
// stimulus.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       sin;
  logic [3:0] pin;
  logic       start;
  logic       dir;

  logic [3:0] q0, q1;
  logic [1:0] q2;
  logic       sout0, sout1, sout2;
  logic       sv0, sv1, sv2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance model state.
  int unsigned mw[3]  = '{4, 4, 2};
  int unsigned mrv[3] = '{0, 10, 1};
  int unsigned mq[3];
  int unsigned mrem[3];
  bit          mbusy[3];
  bit          mdir[3];
  bit          mdone[3];

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .sin(sin), .pin(pin), .start(start),
    .dir(dir), .q(q0), .sout(sout0), .sout_valid(sv0), .busy(busy0), .done(done0)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b1010)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .sin(sin), .pin(pin), .start(start),
    .dir(dir), .q(q1), .sout(sout1), .sout_valid(sv1), .busy(busy1), .done(done1)
  );

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b01)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .sin(sin), .pin(pin[1:0]), .start(start),
    .dir(dir), .q(q2), .sout(sout2), .sout_valid(sv2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs applied to that edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int unsigned w    = mw[i];
      int unsigned mask = (32'd1 << w) - 1;
      int unsigned pv   = 32'(pin) & mask;
      int unsigned shr  = (mq[i] >> 1) | (32'(sin) << (w - 1));
      int unsigned shl  = ((mq[i] << 1) | 32'(sin)) & mask;
      if (rst) begin
        mq[i] = mrv[i]; mbusy[i] = 0; mrem[i] = 0; mdir[i] = 0; mdone[i] = 0;
      end else if (mbusy[i]) begin
        mq[i]   = mdir[i] ? shl : shr;
        mrem[i] = mrem[i] - 1;
        mdone[i] = (mrem[i] == 0);
        if (mrem[i] == 0) mbusy[i] = 0;
      end else begin
        mdone[i] = 0;
        if (start) begin
          mq[i] = pv; mdir[i] = dir; mbusy[i] = 1; mrem[i] = w;
        end else begin
          case (mode)
            2'b01:   mq[i] = shr;
            2'b10:   mq[i] = shl;
            2'b11:   mq[i] = pv;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] qa[3];
    logic       so[3], va[3], ba[3], da[3];
    qa[0] = q0; qa[1] = q1; qa[2] = {2'b00, q2};
    so[0] = sout0; so[1] = sout1; so[2] = sout2;
    va[0] = sv0; va[1] = sv1; va[2] = sv2;
    ba[0] = busy0; ba[1] = busy1; ba[2] = busy2;
    da[0] = done0; da[1] = done1; da[2] = done2;
    for (int i = 0; i < 3; i++) begin
      int unsigned esout = mdir[i] ? ((mq[i] >> (mw[i] - 1)) & 1) : (mq[i] & 1);
      check($sformatf("q[%0d]", i), 32'(qa[i]), mq[i]);
      check($sformatf("busy[%0d]", i), 32'(ba[i]), 32'(mbusy[i]));
      check($sformatf("sout_valid[%0d]", i), 32'(va[i]), 32'(mbusy[i]));
      check($sformatf("done[%0d]", i), 32'(da[i]), 32'(mdone[i]));
      check($sformatf("sout[%0d]", i), 32'(so[i]), esout);
    end
  endtask

  // Applies inputs for one edge, advances the model, then checks on the falling edge.
  task automatic step(input logic r, input logic [1:0] m, input logic s,
                      input logic [3:0] p, input logic st, input logic d);
    rst = r; mode = m; sin = s; pin = p; start = st; dir = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; sin = 1'b0; pin = 4'h0; start = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mrem[i] = 0; mbusy[i] = 0; mdir[i] = 0; mdone[i] = 0;
    end
    @(negedge clk);

    // Reset.
    step(1, 2'b00, 0, 4'h0, 0, 0);
    check("reset q0", 32'(q0), 32'h0);
    check("reset q1", 32'(q1), 32'hA);
    check("reset busy0", 32'(busy0), 32'h0);

    // Manual sequence.
    step(0, 2'b11, 0, 4'b1011, 0, 0);
    check("load", 32'(q0), 32'b1011);
    step(0, 2'b01, 1, 4'h0, 0, 0);
    check("shr", 32'(q0), 32'b1101);
    step(0, 2'b10, 0, 4'h0, 0, 0);
    check("shl", 32'(q0), 32'b1010);
    for (int k = 0; k < 3; k++) step(0, 2'b00, 1, 4'hF, 0, 1);
    check("hold", 32'(q0), 32'b1010);

    // Right burst: sin 1,0,0,1 at E1..E4.
    step(0, 2'b00, 0, 4'b1011, 1, 0);
    check("rb busy", 32'(busy0), 32'h1);
    check("rb sout1", 32'(sout0), 32'h1);
    step(0, 2'b00, 1, 4'h0, 0, 0);
    step(0, 2'b00, 0, 4'h0, 0, 0);
    step(0, 2'b00, 0, 4'h0, 0, 0);
    step(0, 2'b00, 1, 4'h0, 0, 0);
    check("rb q", 32'(q0), 32'b1001);
    check("rb done", 32'(done0), 32'h1);
    step(0, 2'b00, 0, 4'h0, 0, 0);
    check("rb done pulse", 32'(done0), 32'h0);

    // Left burst, sin low throughout.
    step(0, 2'b00, 0, 4'b1011, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 2'b00, 0, 4'h0, 0, 0);
    check("lb q", 32'(q0), 32'h0);
    check("lb done", 32'(done0), 32'h1);

    // start beats mode=11, re-pulse mid-run ignored, start in done cycle accepted.
    step(0, 2'b11, 0, 4'b0110, 1, 0);
    check("prio busy", 32'(busy0), 32'h1);
    step(0, 2'b11, 1, 4'hF, 0, 0);
    step(0, 2'b11, 0, 4'hF, 1, 1);
    step(0, 2'b11, 1, 4'hF, 0, 1);
    step(0, 2'b00, 1, 4'hF, 0, 1);
    check("mid start done", 32'(done0), 32'h1);
    step(0, 2'b00, 0, 4'b1011, 1, 1);
    check("b2b busy", 32'(busy0), 32'h1);
    for (int k = 0; k < 4; k++) step(0, 2'b00, 1, 4'h0, 0, 0);

    // Reset mid-burst after E2.
    step(0, 2'b00, 0, 4'b1111, 1, 0);
    step(0, 2'b00, 1, 4'h0, 0, 0);
    step(0, 2'b00, 1, 4'h0, 0, 0);
    step(1, 2'b00, 1, 4'h0, 0, 0);
    check("abort q", 32'(q0), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(0, 2'b00, 1, 4'h0, 0, 0);
      check("abort done", 32'(done0), 32'h0);
    end

    // Random stimulus.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 5) == 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
